// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: sync rx, qualify start, centre-sample DATA_BITS, check stop (+ parity under UART_RX_PARITY_EN).
// Latency: 2 clk synchroniser + tick quantisation; result pulses one clk after the mid-stop-bit tick.
// Backpressure: none; data_valid is a one-clk pulse and a consumer that misses it loses the word.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 oversampling_clk,
    input  logic [4:0]           oversampling_factor,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PAR_ODD = (PARITY_ODD != 0);
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_deserializer: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
    end

    state_t               state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 osc_q;
    logic                 tick;
    logic [4:0]           ovs_q;
    logic [4:0]           ovs_next;
    logic [4:0]           cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 half_bit;
    logic                 full_bit;

    assign tick     = oversampling_clk & ~osc_q;
    // Fewer than 4 samples per bit leaves no usable centre point.
    assign ovs_next = (oversampling_factor < 5'd4) ? 5'd4 : oversampling_factor;
    assign half_bit = (cnt == ((ovs_q >> 1) - 5'd1));
    assign full_bit = (cnt == (ovs_q - 5'd1));

`ifdef UART_RX_PARITY_EN
    logic par_mis;
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            osc_q         <= 1'b0;
            ovs_q         <= 5'd0;
            cnt           <= 5'd0;
            bit_idx       <= 3'd0;
            shreg         <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_mis       <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            rx_meta       <= rx;
            rx_sync       <= rx_meta;
            osc_q         <= oversampling_clk;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_sync) begin
                            state <= START;
                            cnt   <= 5'd0;
                            ovs_q <= ovs_next;
                            busy  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            par_mis <= 1'b0;
`endif
                        end
                    end
                    START: begin
                        if (half_bit) begin
                            // A line back high at mid-start is noise, not a frame.
                            if (!rx_sync) begin
                                cnt     <= 5'd0;
                                bit_idx <= 3'd0;
                                state   <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    DATA: begin
                        if (full_bit) begin
                            shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
                            cnt     <= 5'd0;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (full_bit) begin
                            par_mis <= rx_sync ^ (^shreg) ^ PAR_ODD;
                            cnt     <= 5'd0;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
`endif
                    STOP: begin
                        if (full_bit) begin
                            // Leave at mid-stop so an immediately following start edge is seen.
                            cnt           <= 5'd0;
                            state         <= IDLE;
                            busy          <= 1'b0;
                            framing_error <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
                            parity_error  <= par_mis;
                            if (rx_sync && !par_mis) begin
`else
                            if (rx_sync) begin
`endif
                                data       <= shreg;
                                data_valid <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
